// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined barrel shifter (SLL / SRL / SRA / ROL).
// The log2(WIDTH) shift levels are spread over PIPE_STAGES register stages.
// A single global stall freezes every stage while the output is held.
// Each stage register carries valid, partial data, shift amount, mode, tag
// and the original operand sign bit that SRA needs for its fill.

module shift_unit_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_shamt,
    input  logic [1:0]               i_mode,
    input  logic [TAG_W-1:0]         i_tag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [TAG_W-1:0]         o_tag
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // Stage that owns shift level k. The integer division spreads the
    // levels evenly, so every stage receives at least one level.
    function automatic int stage_of(input int k);
        return (k * PIPE_STAGES) / SHW;
    endfunction

    // One shift level: shift d by amt (a power of two below WIDTH) using
    // the fill rule of the selected mode.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = {WIDTH{sign}} << (WIDTH - amt);
        case (mode)
            MODE_SLL: res = d << amt;
            MODE_SRL: res = d >> amt;
            MODE_SRA: res = (d >> amt) | fill;
            MODE_ROL: res = (d << amt) | (d >> (WIDTH - amt));
            default:  res = d;
        endcase
        return res;
    endfunction

    // Stage registers
    logic               r_valid [PIPE_STAGES];
    logic [WIDTH-1:0]   r_data  [PIPE_STAGES];
    logic [SHW-1:0]     r_shamt [PIPE_STAGES];
    logic [1:0]         r_mode  [PIPE_STAGES];
    logic [TAG_W-1:0]   r_tag   [PIPE_STAGES];
    logic               r_sign  [PIPE_STAGES];

    // Next-state values for every stage
    logic               w_nxt_valid [PIPE_STAGES];
    logic [WIDTH-1:0]   w_nxt_data  [PIPE_STAGES];
    logic [SHW-1:0]     w_nxt_shamt [PIPE_STAGES];
    logic [1:0]         w_nxt_mode  [PIPE_STAGES];
    logic [TAG_W-1:0]   w_nxt_tag   [PIPE_STAGES];
    logic               w_nxt_sign  [PIPE_STAGES];

    // Predecessor values walked along the chain inside the comb block
    logic               w_p_valid;
    logic [WIDTH-1:0]   w_p_data;
    logic [SHW-1:0]     w_p_shamt;
    logic [1:0]         w_p_mode;
    logic [TAG_W-1:0]   w_p_tag;
    logic               w_p_sign;
    logic [WIDTH-1:0]   w_acc;

    logic               w_advance;

    // Global stall: everything moves unless a result is held for downstream
    always_comb begin
        if (r_valid[PIPE_STAGES-1] && !i_ready) begin
            w_advance = 1'b0;
        end else begin
            w_advance = 1'b1;
        end
    end

    // Shift network: each stage applies the levels it owns to its predecessor
    always_comb begin
        w_p_valid = i_valid;
        w_p_data  = i_data;
        w_p_shamt = i_shamt;
        w_p_mode  = i_mode;
        w_p_tag   = i_tag;
        w_p_sign  = i_data[WIDTH-1];
        w_acc     = {WIDTH{1'b0}};
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_acc = w_p_data;
            for (int k = 0; k < SHW; k++) begin
                w_acc = ((stage_of(k) == s) && w_p_shamt[k])
                      ? shift_level(w_acc, w_p_mode, w_p_sign, 32'sd1 << k)
                      : w_acc;
            end
            w_nxt_valid[s] = w_p_valid;
            w_nxt_data[s]  = w_acc;
            w_nxt_shamt[s] = w_p_shamt;
            w_nxt_mode[s]  = w_p_mode;
            w_nxt_tag[s]   = w_p_tag;
            w_nxt_sign[s]  = w_p_sign;
            w_p_valid = r_valid[s];
            w_p_data  = r_data[s];
            w_p_shamt = r_shamt[s];
            w_p_mode  = r_mode[s];
            w_p_tag   = r_tag[s];
            w_p_sign  = r_sign[s];
        end
    end

    // Stage registers: clear on reset, shift together on advance, else hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_data[s]  <= {WIDTH{1'b0}};
                r_shamt[s] <= {SHW{1'b0}};
                r_mode[s]  <= 2'b00;
                r_tag[s]   <= {TAG_W{1'b0}};
                r_sign[s]  <= 1'b0;
            end
        end else if (w_advance) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid[s] <= w_nxt_valid[s];
                r_data[s]  <= w_nxt_data[s];
                r_shamt[s] <= w_nxt_shamt[s];
                r_mode[s]  <= w_nxt_mode[s];
                r_tag[s]   <= w_nxt_tag[s];
                r_sign[s]  <= w_nxt_sign[s];
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid[s] <= r_valid[s];
                r_data[s]  <= r_data[s];
                r_shamt[s] <= r_shamt[s];
                r_mode[s]  <= r_mode[s];
                r_tag[s]   <= r_tag[s];
                r_sign[s]  <= r_sign[s];
            end
        end
    end

    assign o_ready = w_advance;
    assign o_valid = r_valid[PIPE_STAGES-1];
    assign o_data  = r_data[PIPE_STAGES-1];
    assign o_tag   = r_tag[PIPE_STAGES-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: directed cases, backpressure,
// asynchronous reset, and a randomized back-to-back sweep over four
// parameter sets checked against a whole-shift arithmetic reference model.

module tb_shift_unit_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = 32'd0;
    logic [4:0]  i_shamt = 5'd0;
    logic [1:0]  i_mode = 2'd0;
    logic [3:0]  i_tag = 4'd0;
    logic        i_ready = 1'b1;

    logic        o_ready, o_valid;
    logic [31:0] o_data;
    logic [3:0]  o_tag;

    logic        unused_rdy_p1, unused_rdy_p5, unused_rdy_w8;
    logic        o_valid_p1, o_valid_p5, o_valid_w8;
    logic [31:0] o_data_p1, o_data_p5;
    logic [7:0]  o_data_w8;
    logic [3:0]  o_tag_p1, o_tag_p5, o_tag_w8;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp32 [16];
    logic [31:0] exp8  [16];

    always #5 i_clk = ~i_clk;

    shift_unit_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_shamt(i_shamt), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag));

    shift_unit_pipe #(.WIDTH(32), .PIPE_STAGES(1), .TAG_W(4)) u_p1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(unused_rdy_p1),
        .i_data(i_data), .i_shamt(i_shamt), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid_p1), .i_ready(i_ready), .o_data(o_data_p1), .o_tag(o_tag_p1));

    shift_unit_pipe #(.WIDTH(32), .PIPE_STAGES(5), .TAG_W(4)) u_p5 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(unused_rdy_p5),
        .i_data(i_data), .i_shamt(i_shamt), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid_p5), .i_ready(i_ready), .o_data(o_data_p5), .o_tag(o_tag_p5));

    shift_unit_pipe #(.WIDTH(8), .PIPE_STAGES(3), .TAG_W(4)) u_w8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(unused_rdy_w8),
        .i_data(i_data[7:0]), .i_shamt(i_shamt[2:0]), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid_w8), .i_ready(i_ready), .o_data(o_data_w8), .o_tag(o_tag_w8));

    // Reference: the complete shift done in one step with wide arithmetic
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                              input logic [1:0] m, input int w);
        logic [63:0]        mask, x, r;
        logic signed [63:0] sx;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        case (m)
            2'd0: r = x << sh;
            2'd1: r = x >> sh;
            2'd2: begin
                sx = x[w-1] ? $signed(x | ~mask) : $signed(x);
                r  = sx >>> sh;
            end
            2'd3: r = (x << sh) | (x >> (w - sh));
            default: r = 64'd0;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // One isolated request with full-rate downstream; latency is exactly 2
    task automatic do_op(input string nm, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] m, input logic [3:0] tg, input logic [31:0] exp);
        @(negedge i_clk);
        i_valid = 1'b1; i_data = d; i_shamt = sh; i_mode = m; i_tag = tg;
        @(negedge i_clk);
        i_valid = 1'b0;
        check({nm, "_lat1_valid"}, {31'd0, o_valid}, 32'd0);
        @(negedge i_clk);
        check({nm, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({nm, "_data"}, o_data, exp);
        check({nm, "_tag"}, {28'd0, o_tag}, {28'd0, tg});
    endtask

    // Sweep check for one instance after rising edge p (latency lat)
    task automatic chk_out(input string nm, input int lat, input int p, input logic v,
                           input logic [31:0] d, input logic [3:0] t, input logic [31:0] ex [16]);
        int j;
        j = p - lat + 1;
        if (j >= 0 && j < 16) begin
            check({nm, "_valid"}, {31'd0, v}, 32'd1);
            check({nm, "_data"}, d, ex[j]);
            check({nm, "_tag"}, {28'd0, t}, 32'(j));
        end else begin
            check({nm, "_idle"}, {31'd0, v}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ea, eb, ec, rd;
        logic [4:0]  rs;
        logic [1:0]  rm;

        // Reset state
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_tag", {28'd0, o_tag}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed shifts
        do_op("sll31", 32'h00000001, 5'd31, 2'd0, 4'd3, 32'h80000000);
        do_op("sll4", 32'h12345678, 5'd4, 2'd0, 4'd4, 32'h23456780);
        do_op("srl4", 32'h80000000, 5'd4, 2'd1, 4'd5, 32'h08000000);
        do_op("sra4", 32'h80000000, 5'd4, 2'd2, 4'd6, 32'hF8000000);
        do_op("sra31", 32'h7FFFFFFF, 5'd31, 2'd2, 4'd7, 32'h00000000);
        do_op("rol1", 32'h80000001, 5'd1, 2'd3, 4'd8, 32'h00000003);
        do_op("rol16", 32'hDEADBEEF, 5'd16, 2'd3, 4'd9, 32'hBEEFDEAD);
        for (int m = 0; m < 4; m++)
            do_op("zero", 32'hDEADBEEF, 5'd0, 2'(m), 4'(m), 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            rd = $urandom; rs = 5'($urandom_range(31, 0)); rm = 2'($urandom_range(3, 0));
            do_op("rand", rd, rs, rm, 4'(i + 10), ref_shift(rd, int'(rs), rm, 32));
        end

        // Backpressure: tags 1,2,3 then a 5-edge stall
        @(negedge i_clk);
        rd = $urandom; rs = 5'($urandom_range(31, 0)); rm = 2'($urandom_range(3, 0));
        ea = ref_shift(rd, int'(rs), rm, 32);
        i_valid = 1'b1; i_data = rd; i_shamt = rs; i_mode = rm; i_tag = 4'd1;
        @(negedge i_clk);
        rd = $urandom; rs = 5'($urandom_range(31, 0)); rm = 2'($urandom_range(3, 0));
        eb = ref_shift(rd, int'(rs), rm, 32);
        i_data = rd; i_shamt = rs; i_mode = rm; i_tag = 4'd2;
        @(negedge i_clk);
        rd = $urandom; rs = 5'($urandom_range(31, 0)); rm = 2'($urandom_range(3, 0));
        ec = ref_shift(rd, int'(rs), rm, 32);
        i_data = rd; i_shamt = rs; i_mode = rm; i_tag = 4'd3;
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("bp_stall_ready", {31'd0, o_ready}, 32'd0);
            check("bp_stall_valid", {31'd0, o_valid}, 32'd1);
            check("bp_stall_tag", {28'd0, o_tag}, 32'd1);
            check("bp_stall_data", o_data, ea);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("bp_t2_valid", {31'd0, o_valid}, 32'd1);
        check("bp_t2_tag", {28'd0, o_tag}, 32'd2);
        check("bp_t2_data", o_data, eb);
        @(negedge i_clk);
        check("bp_t3_valid", {31'd0, o_valid}, 32'd1);
        check("bp_t3_tag", {28'd0, o_tag}, 32'd3);
        check("bp_t3_data", o_data, ec);
        @(negedge i_clk);
        check("bp_drain", {31'd0, o_valid}, 32'd0);

        // Reset with two operations in flight
        @(negedge i_clk);
        i_valid = 1'b1; i_data = 32'hFFFFFFFF; i_shamt = 5'd1; i_mode = 2'd0; i_tag = 4'd12;
        @(negedge i_clk);
        i_tag = 4'd13;
        @(negedge i_clk);
        check("mid_inflight", {31'd0, o_valid}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_data", o_data, 32'd0);
        check("mid_rst_tag", {28'd0, o_tag}, 32'd0);
        check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("post_rst_idle", {31'd0, o_valid}, 32'd0);
        end

        // Clean start for the sweep
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 16 back-to-back random ops on all four parameter sets
        for (int p = 0; p < 21; p++) begin
            @(negedge i_clk);
            if (p < 16) begin
                i_valid = 1'b1;
                i_data  = $urandom;
                i_shamt = 5'($urandom_range(31, 0));
                i_mode  = 2'($urandom_range(3, 0));
                i_tag   = 4'(p);
                exp32[p] = ref_shift(i_data, int'(i_shamt), i_mode, 32);
                exp8[p]  = ref_shift({24'd0, i_data[7:0]}, int'(i_shamt[2:0]), i_mode, 8);
            end else begin
                i_valid = 1'b0;
            end
            @(posedge i_clk);
            #1;
            chk_out("sw_p2", 2, p, o_valid, o_data, o_tag, exp32);
            chk_out("sw_p1", 1, p, o_valid_p1, o_data_p1, o_tag_p1, exp32);
            chk_out("sw_p5", 5, p, o_valid_p5, o_data_p5, o_tag_p5, exp32);
            chk_out("sw_w8", 3, p, o_valid_w8, {24'd0, o_data_w8}, o_tag_w8, exp8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
